ftdi_link_scheduler: RTL and testbench

Controller that sequences the FTDI asynchronous-FIFO interface block for the laser link.
- Drives the interface's rd_en/wr_en, rdreq/wrreq and clear.
- Time-slices the shared half-duplex ADBUS between host→FPGA reads and FPGA→host writes.
- Pumps fixed-length packets out of the host read queue into the laser TX stream.
- Pushes laser RX bytes into the host write queue, counting drops.

---
 rtl/ftdi_link_scheduler_if.sv | 25 ++
 rtl/ftdi_link_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_ftdi_link_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ftdi_link_scheduler_if.sv
// Signal bundle between the link scheduler (master) and the FTDI async-FIFO interface block (slave).
interface ftdi_link_scheduler_if;
    logic       fi_rdq_empty;
    logic       fi_rdq_full;
    logic       fi_wrq_full;
    logic       fi_wrq_empty;
    logic [9:0] fi_qsize;
    logic [7:0] fi_data_rd;
    logic       fi_rd_en;
    logic       fi_wr_en;
    logic       fi_rdreq;
    logic       fi_wrreq;
    logic [7:0] fi_data_wr;
    logic       fi_clear;

    modport master (
        input  fi_rdq_empty, fi_rdq_full, fi_wrq_full, fi_wrq_empty, fi_qsize, fi_data_rd,
        output fi_rd_en, fi_wr_en, fi_rdreq, fi_wrreq, fi_data_wr, fi_clear
    );

    modport slave (
        output fi_rdq_empty, fi_rdq_full, fi_wrq_full, fi_wrq_empty, fi_qsize, fi_data_rd,
        input  fi_rd_en, fi_wr_en, fi_rdreq, fi_wrreq, fi_data_wr, fi_clear
    );
endinterface

// File: rtl/ftdi_link_scheduler.sv
// FTDI link scheduler: half-duplex bus-direction arbiter, TX packet pump and RX push path.
// Build macro FTDI_SCHED_STATS_EN adds the pkt_count / switch_count statistics outputs.
module ftdi_link_scheduler #(
    parameter int PKT_LEN    = 64,
    parameter int SLICE      = 256,
    parameter int RD_HIWATER = 960
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    ftdi_link_scheduler_if.master fi,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [15:0]           drop_count,
    output logic                  busy
`ifdef FTDI_SCHED_STATS_EN
    ,
    output logic [15:0]           pkt_count,
    output logic [15:0]           switch_count
`endif
);
    localparam int              TW        = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam logic [TW-1:0]   TIMER_MAX = TW'(SLICE - 1);
    localparam logic [10:0]     HIWATER   = 11'(RD_HIWATER);
    localparam logic [10:0]     PKT_OCC   = 11'(PKT_LEN);
    localparam logic [9:0]      LAST_IDX  = 10'(PKT_LEN - 1);

    typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_t;
    typedef enum logic [1:0] {P_IDLE = 2'd0, P_POP = 2'd1, P_SEND = 2'd2} pump_t;

    dir_t          dir_r, dir_next_s;
    logic [TW-1:0] timer_r, timer_next_s;
    pump_t         state_r;
    logic [9:0]    cnt_r;
    logic          rd_en_r, wr_en_r, clear_r;
    logic          rdreq_r, tx_valid_r, tx_last_r, busy_r;
    logic          wrreq_r;
    logic [7:0]    data_wr_r;
    logic [15:0]   drop_r;
    logic [10:0]   occ_s;
    logic          hiwater_s, pkt_ready_s;

    // Read-queue occupancy; usedw wraps to 0 at 1024 entries, so the full flag supplies the MSB.
    always_comb begin
        occ_s = {1'b0, fi.fi_qsize};
        if (fi.fi_rdq_full) begin
            occ_s = 11'd1024;
        end else begin
            occ_s = {1'b0, fi.fi_qsize};
        end
    end

    assign hiwater_s   = (occ_s >= HIWATER);
    assign pkt_ready_s = (occ_s >= PKT_OCC) && !fi.fi_rdq_empty;

    // Next bus direction and slice timer; a side keeps the bus while the other has no work.
    always_comb begin
        dir_next_s   = dir_r;
        timer_next_s = (timer_r == TIMER_MAX) ? timer_r : timer_r + TW'(1);
        case (dir_r)
            DIR_RD: begin
                if (!fi.fi_wrq_empty && ((timer_r == TIMER_MAX) || hiwater_s)) begin
                    dir_next_s   = DIR_WR;
                    timer_next_s = {TW{1'b0}};
                end else begin
                    dir_next_s   = DIR_RD;
                end
            end
            DIR_WR: begin
                if (fi.fi_wrq_empty || ((timer_r == TIMER_MAX) && !hiwater_s)) begin
                    dir_next_s   = DIR_RD;
                    timer_next_s = {TW{1'b0}};
                end else begin
                    dir_next_s   = DIR_WR;
                end
            end
            default: begin
                dir_next_s   = DIR_RD;
                timer_next_s = {TW{1'b0}};
            end
        endcase
    end

    // Direction register, registered bus enables and the one-cycle clear pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            dir_r   <= DIR_RD;
            timer_r <= {TW{1'b0}};
            rd_en_r <= 1'b1;
            wr_en_r <= 1'b0;
            clear_r <= 1'b0;
        end else if (clear_req) begin
            dir_r   <= DIR_RD;
            timer_r <= {TW{1'b0}};
            rd_en_r <= !hiwater_s;
            wr_en_r <= 1'b0;
            clear_r <= 1'b1;
        end else begin
            dir_r   <= dir_next_s;
            timer_r <= timer_next_s;
            rd_en_r <= (dir_next_s == DIR_RD) && !hiwater_s;
            wr_en_r <= (dir_next_s == DIR_WR);
            clear_r <= 1'b0;
        end
    end

    // Packet pump: a packet starts only once all PKT_LEN bytes are queued, then pop/send alternate.
    always_ff @(posedge clock) begin
        if (reset || clear_req) begin
            state_r    <= P_IDLE;
            cnt_r      <= 10'd0;
            rdreq_r    <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_last_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                P_IDLE: begin
                    if (pkt_ready_s) begin
                        state_r <= P_POP;
                        cnt_r   <= 10'd0;
                        rdreq_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        rdreq_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                P_POP: begin
                    state_r    <= P_SEND;
                    rdreq_r    <= 1'b0;
                    tx_valid_r <= 1'b1;
                    tx_last_r  <= (cnt_r == LAST_IDX);
                    busy_r     <= 1'b1;
                end
                P_SEND: begin
                    if (tx_ready) begin
                        tx_valid_r <= 1'b0;
                        tx_last_r  <= 1'b0;
                        if (tx_last_r) begin
                            state_r <= P_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= P_POP;
                            cnt_r   <= cnt_r + 10'd1;
                            rdreq_r <= 1'b1;
                        end
                    end else begin
                        state_r <= P_SEND;
                    end
                end
                default: begin
                    state_r    <= P_IDLE;
                    rdreq_r    <= 1'b0;
                    tx_valid_r <= 1'b0;
                    tx_last_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // RX push stage: one register delay into the write queue, saturating drop counter when full.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrreq_r   <= 1'b0;
            data_wr_r <= 8'h00;
            drop_r    <= 16'h0000;
        end else if (clear_req) begin
            wrreq_r   <= 1'b0;
        end else begin
            if (rx_valid && !fi.fi_wrq_full) begin
                wrreq_r   <= 1'b1;
                data_wr_r <= rx_data;
            end else begin
                wrreq_r   <= 1'b0;
            end
            if (rx_valid && fi.fi_wrq_full && (drop_r != 16'hFFFF)) begin
                drop_r <= drop_r + 16'd1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

`ifdef FTDI_SCHED_STATS_EN
    logic [15:0] pkt_cnt_r, sw_cnt_r;
    logic        pkt_done_s, dir_change_s;

    assign pkt_done_s   = (state_r == P_SEND) && tx_ready && tx_last_r && !clear_req;
    assign dir_change_s = clear_req ? (dir_r == DIR_WR) : (dir_next_s != dir_r);

    // Saturating statistics; only reset zeroes them.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_cnt_r <= 16'h0000;
            sw_cnt_r  <= 16'h0000;
        end else begin
            if (pkt_done_s && (pkt_cnt_r != 16'hFFFF)) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            if (dir_change_s && (sw_cnt_r != 16'hFFFF)) begin
                sw_cnt_r <= sw_cnt_r + 16'd1;
            end else begin
                sw_cnt_r <= sw_cnt_r;
            end
        end
    end

    assign pkt_count    = pkt_cnt_r;
    assign switch_count = sw_cnt_r;
`endif

    // fi_data_rd is held by the interface until the next pop, so it is forwarded while valid.
    assign tx_data       = tx_valid_r ? fi.fi_data_rd : 8'h00;
    assign tx_valid      = tx_valid_r;
    assign tx_last       = tx_last_r;
    assign busy          = busy_r;
    assign drop_count    = drop_r;
    assign fi.fi_rd_en   = rd_en_r;
    assign fi.fi_wr_en   = wr_en_r;
    assign fi.fi_rdreq   = rdreq_r;
    assign fi.fi_wrreq   = wrreq_r;
    assign fi.fi_data_wr = data_wr_r;
    assign fi.fi_clear   = clear_r;
endmodule

// File: tb/tb_ftdi_link_scheduler.sv
// Self-checking bench for ftdi_link_scheduler: models the FTDI read queue and scores TX/RX behaviour.
module tb_ftdi_link_scheduler;
    localparam int PKT_LEN    = 4;
    localparam int SLICE      = 8;
    localparam int RD_HIWATER = 960;

    logic        clock = 1'b0;
    logic        reset, clear_req, tx_ready, rx_valid;
    logic [7:0]  rx_data, tx_data;
    logic        tx_valid, tx_last, busy;
    logic [15:0] drop_count;
`ifdef FTDI_SCHED_STATS_EN
    logic [15:0] pkt_count, switch_count;
`endif

    ftdi_link_scheduler_if fi ();

    ftdi_link_scheduler #(.PKT_LEN(PKT_LEN), .SLICE(SLICE), .RD_HIWATER(RD_HIWATER)) dut (
        .clock(clock), .reset(reset), .clear_req(clear_req), .fi(fi),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .drop_count(drop_count), .busy(busy)
`ifdef FTDI_SCHED_STATS_EN
        , .pkt_count(pkt_count), .switch_count(switch_count)
`endif
    );

    always #5 clock = ~clock;

    logic [7:0] rdq[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rd_q_r;
    int checks = 0, errors = 0;
    int rdreq_cnt = 0, wrreq_cnt = 0, beat_idx = 0, beats_total = 0, last_cnt = 0;
    int cycle = 0, exp_drop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drive_fifo();
        fi.fi_qsize     = 10'(rdq.size());
        fi.fi_rdq_full  = (rdq.size() >= 1024);
        fi.fi_rdq_empty = (rdq.size() == 0);
        fi.fi_data_rd   = rd_q_r;
    endtask

    task automatic push(input logic [7:0] b);
        rdq.push_back(b);
        exp_tx.push_back(b);
        drive_fifo();
    endtask

    // One clock: sample at negedge, let the edge happen, then update the queue model and score.
    task automatic step();
        logic       pre_rdreq, pre_acc, pre_stall, pre_clr, pre_rst, pre_rx_ok, pre_rx_drop, pre_last;
        logic [7:0] pre_txd, pre_rxd;
        @(negedge clock);
        pre_rdreq   = fi.fi_rdreq;
        pre_clr     = clear_req;
        pre_rst     = reset;
        pre_acc     = tx_valid && tx_ready && !clear_req && !reset;
        pre_stall   = tx_valid && !tx_ready && !clear_req && !reset;
        pre_txd     = tx_data;
        pre_last    = tx_last;
        pre_rx_ok   = rx_valid && !fi.fi_wrq_full && !clear_req && !reset;
        pre_rx_drop = rx_valid && fi.fi_wrq_full && !clear_req && !reset;
        pre_rxd     = rx_data;
        if (pre_acc) begin
            if (exp_tx.size() == 0) begin
                chk("tx_unexpected_beat", 32'd1, 32'd0);
            end else begin
                chk("tx_data", pre_txd, exp_tx.pop_front());
                chk("tx_last", pre_last, ((beat_idx % PKT_LEN) == PKT_LEN - 1));
            end
            if (pre_last) last_cnt++;
            beat_idx++;
            beats_total++;
        end
        @(posedge clock);
        #1;
        cycle++;
        if (pre_rdreq) begin
            rdreq_cnt++;
            if (rdq.size() == 0) chk("rdq_underflow", 32'd1, 32'd0);
            else rd_q_r = rdq.pop_front();
        end
        if (pre_clr || pre_rst) begin
            rdq.delete();
            exp_tx.delete();
            beat_idx = 0;
        end
        if (pre_rst) exp_drop = 0;
        else if (pre_rx_drop && exp_drop < 65535) exp_drop++;
        chk("rx_wrreq", fi.fi_wrreq, pre_rx_ok);
        if (pre_rx_ok) chk("rx_data_wr", fi.fi_data_wr, pre_rxd);
        chk("drop_count", drop_count, exp_drop);
        chk("en_exclusive", fi.fi_rd_en & fi.fi_wr_en, 32'd0);
        chk("clear_pulse", fi.fi_clear, pre_clr && !pre_rst);
        if (pre_stall) chk("stall_hold", {tx_valid, tx_data, tx_last}, {1'b1, pre_txd, pre_last});
        if (fi.fi_wrreq) wrreq_cnt++;
        drive_fifo();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int start, k;
        start = beats_total;
        k = 0;
        while ((beats_total - start) < n && k < budget) begin
            step();
            k++;
        end
        if ((beats_total - start) < n) chk("timeout_beats", beats_total - start, n);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!tx_valid && k < budget) begin
            step();
            k++;
        end
        if (!tx_valid) chk("timeout_valid", tx_valid, 32'd1);
    endtask

    initial begin
        int pops0, w0, t_last, n_tog, k;
        logic prev_wr;

        reset = 1'b1; clear_req = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        fi.fi_wrq_full = 1'b0; fi.fi_wrq_empty = 1'b1; rd_q_r = 8'h00;
        drive_fifo();
        step(); step();
        chk("rst_rd_en", fi.fi_rd_en, 32'd1);
        chk("rst_wr_en", fi.fi_wr_en, 32'd0);
        chk("rst_rdreq", fi.fi_rdreq, 32'd0);
        chk("rst_tx", {tx_valid, tx_last, tx_data}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_data_wr", fi.fi_data_wr, 32'd0);
        reset = 1'b0;

        // Three bytes must not start a packet; the fourth does.
        tx_ready = 1'b1;
        push(8'hA0); push(8'hA1); push(8'hA2);
        repeat (10) step();
        chk("no_pop_at_occ3", rdreq_cnt, 32'd0);
        chk("idle_at_occ3", busy, 32'd0);
        push(8'hA3);
        wait_beats(4, 40);
        chk("pops_per_pkt", rdreq_cnt, 32'd4);
        chk("last_count", last_cnt, 32'd1);
        chk("idle_after_pkt", busy, 32'd0);

        // Backpressure: ten cycles without tx_ready.
        tx_ready = 1'b0;
        for (int i = 0; i < PKT_LEN; i++) push(8'($urandom));
        wait_valid(10);
        pops0 = rdreq_cnt;
        repeat (10) step();
        chk("stall_no_pop", rdreq_cnt - pops0, 32'd0);
        chk("stall_valid", tx_valid, 32'd1);
        tx_ready = 1'b1;
        wait_beats(4, 40);
        chk("stall_pkt_pops", rdreq_cnt, 32'd8);

        // Five RX beats into a full write queue are all dropped.
        fi.fi_wrq_full = 1'b1;
        w0 = wrreq_cnt;
        repeat (5) begin
            rx_valid = 1'b1; rx_data = 8'($urandom);
            step();
        end
        rx_valid = 1'b0;
        step();
        chk("drop_no_wrreq", wrreq_cnt - w0, 32'd0);
        chk("drop5", drop_count, 32'd5);
        fi.fi_wrq_full = 1'b0;

        // Randomized traffic on both paths.
        for (int i = 0; i < 600; i++) begin
            tx_ready       = 1'($urandom_range(0, 1));
            rx_valid       = 1'($urandom_range(0, 1));
            rx_data        = 8'($urandom);
            fi.fi_wrq_full = ($urandom_range(0, 3) == 0);
            fi.fi_wrq_empty = 1'($urandom_range(0, 1));
            if (rdq.size() < 20 && $urandom_range(0, 2) == 0) push(8'($urandom));
            step();
        end
        tx_ready = 1'b1; rx_valid = 1'b0; fi.fi_wrq_full = 1'b0;
        k = 0;
        while ((busy || exp_tx.size() >= PKT_LEN) && k < 100) begin
            step();
            k++;
        end
        chk("rand_drained", busy, 32'd0);

        // Slice alternation with pending writes and an empty read queue.
        fi.fi_wrq_empty = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        prev_wr = fi.fi_wr_en;
        t_last = cycle;
        n_tog = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            chk("rd_en_mirror", fi.fi_rd_en, !fi.fi_wr_en);
            if (fi.fi_wr_en !== prev_wr) begin
                chk("slice_len", cycle - t_last, SLICE);
                t_last = cycle;
                prev_wr = fi.fi_wr_en;
                n_tog++;
            end
        end
        chk("slice_toggles", n_tog, 32'd7);

        // Full read queue (usedw wrapped to 0): reads paused, packet starts.
        fi.fi_wrq_empty = 1'b1;
        tx_ready = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 1024; i++) push(8'($urandom));
        chk("full_qsize_wrapped", fi.fi_qsize, 32'd0);
        repeat (4) step();
        chk("full_rd_en", fi.fi_rd_en, 32'd0);
        chk("full_busy", busy, 32'd1);
        chk("full_valid", tx_valid, 32'd1);
        fi.fi_wrq_empty = 1'b0;
        repeat (2) step();
        chk("hiwater_to_wr", fi.fi_wr_en, 32'd1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_from_wr", fi.fi_wr_en, 32'd0);
        step();
        chk("clr_rd_dir", fi.fi_rd_en, 32'd1);

        // Clear while the second byte of a packet is on the bus.
        fi.fi_wrq_empty = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < PKT_LEN; i++) push(8'($urandom));
        k = 0;
        while (!(beat_idx == 1 && tx_valid) && k < 20) begin
            step();
            k++;
        end
        chk("clr_reach_byte2", beat_idx == 1 && tx_valid, 32'd1);
        rx_valid = 1'b1; rx_data = 8'h5A; clear_req = 1'b1;
        step();
        rx_valid = 1'b0; clear_req = 1'b0;
        chk("clr_fi_clear", fi.fi_clear, 32'd1);
        chk("clr_tx", {tx_valid, tx_last}, 32'd0);
        chk("clr_busy", busy, 32'd0);
        chk("clr_dir", {fi.fi_rd_en, fi.fi_wr_en}, 32'd2);
        chk("clr_rx_discard", fi.fi_wrreq, 32'd0);
        chk("clr_drop_kept", drop_count, exp_drop);
        step();
        chk("clr_pulse_end", fi.fi_clear, 32'd0);
        chk("clr_no_restart", busy, 32'd0);

        // Drop counter saturation.
        fi.fi_wrq_full = 1'b1;
        rx_valid = 1'b1;
        repeat (70000) step();
        chk("drop_sat", drop_count, 32'hFFFF);
        rx_valid = 1'b0;
        fi.fi_wrq_full = 1'b0;

        // Reset in the middle of a packet and an RX transfer.
        tx_ready = 1'b0;
        for (int i = 0; i < PKT_LEN; i++) push(8'($urandom));
        wait_valid(10);
        rx_valid = 1'b1; rx_data = 8'h3C;
        step();
        chk("mid_rx_pending", fi.fi_wrreq, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; rx_valid = 1'b0;
        chk("mrst_rd_en", fi.fi_rd_en, 32'd1);
        chk("mrst_wr_en", fi.fi_wr_en, 32'd0);
        chk("mrst_rdreq_wrreq", {fi.fi_rdreq, fi.fi_wrreq, fi.fi_clear}, 32'd0);
        chk("mrst_tx", {tx_valid, tx_last, tx_data}, 32'd0);
        chk("mrst_busy", busy, 32'd0);
        chk("mrst_drop", drop_count, 32'd0);
        chk("mrst_data_wr", fi.fi_data_wr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
